// File: rtl/adder_rr_scheduler.sv
// rtl/adder_rr_scheduler.sv - round-robin scheduler sharing one registered adder among N_REQ requesters
// Define ADDER_SCHED_SAT_EN to clamp sums at 2^W-1 instead of keeping the carry bit.
module adder_rr_scheduler #(
  parameter  int N_REQ = 2,
  parameter  int W     = 4,
  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] op_a,
  input  logic [N_REQ*W-1:0] op_b,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               res_valid,
  output logic [W:0]         res_data,
  output logic [IDW-1:0]     res_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [W-1:0]     opa_q, opa_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [W:0]       sum_q, sum_d;
  logic             res_valid_q, res_valid_d;
  logic [W:0]       res_data_q, res_data_d;
  logic [IDW-1:0]   res_id_q, res_id_d;

  logic [IDW-1:0]   win_idx;
  logic             win_found;
  logic [W:0]       raw_sum;
  logic [W:0]       exec_sum;

  // Scan from ptr upward with explicit wrap so a non-power-of-2 N_REQ never yields an index >= N_REQ.
  always_comb begin
    int k;
    k         = 0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      k = int'(ptr_q) + j;
      if (k >= N_REQ) k = k - N_REQ;
      if (!win_found && req[k[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = k[IDW-1:0];
      end
    end
  end

  assign raw_sum = {1'b0, opa_q} + {1'b0, opb_q};

`ifdef ADDER_SCHED_SAT_EN
  assign exec_sum = raw_sum[W] ? {1'b0, {W{1'b1}}} : raw_sum;
`else
  assign exec_sum = raw_sum;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = '0;
    opa_d       = opa_q;
    opb_d       = opb_q;
    id_d        = id_q;
    sum_d       = sum_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = N_REQ'(1) << win_idx;
          opa_d   = op_a[win_idx*W +: W];
          opb_d   = op_b[win_idx*W +: W];
          id_d    = win_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        sum_d   = exec_sum;
        state_d = DONE;
      end
      DONE: begin
        res_valid_d = 1'b1;
        res_data_d  = sum_q;
        res_id_d    = id_q;
        ptr_d       = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + IDW'(1);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      id_q        <= '0;
      sum_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      id_q        <= id_d;
      sum_q       <= sum_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == EXEC) || (state_q == DONE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb/tb_adder_rr_scheduler.sv - randomized self-checking bench for adder_rr_scheduler
// Honours ADDER_SCHED_SAT_EN in its reference model and directed expectations.
module tb_adder_rr_scheduler;
  localparam int N   = 2;
  localparam int W   = 4;
  localparam int IDW = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a;
  logic [N*W-1:0] op_b;
  logic [N-1:0]   grant;
  logic           busy;
  logic           res_valid;
  logic [W:0]     res_data;
  logic [IDW-1:0] res_id;

  int n_cmp = 0;
  int n_bad = 0;

  // transaction-level reference: cycles left in the current op, rotation pointer, pending result
  int m_left = 0;
  int m_ptr  = 0;
  int m_id   = 0;
  int m_sum  = 0;
  int e_grant = 0, e_valid = 0, e_data = 0, e_id = 0;

  int tick_no = 0;

  adder_rr_scheduler #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .grant     (grant),
    .busy      (busy),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @tick %0d: got %0h expected %0h", tag, tick_no, got, exp);
    end
  endtask

  function automatic int add_ref(input int a, input int b);
    int s;
    s = a + b;
`ifdef ADDER_SCHED_SAT_EN
    if (s > (1 << W) - 1) s = (1 << W) - 1;
`endif
    return s;
  endfunction

  task automatic model_step();
    int w;
    bit found;
    if (rst) begin
      m_left = 0; m_ptr = 0; e_grant = 0; e_valid = 0; e_data = 0; e_id = 0;
    end else begin
      e_grant = 0;
      e_valid = 0;
      if (m_left == 0) begin
        found = 0;
        w = 0;
        for (int j = 0; j < N; j++) begin
          if (!found && req[(m_ptr + j) % N]) begin
            found = 1;
            w = (m_ptr + j) % N;
          end
        end
        if (found) begin
          e_grant = 1 << w;
          m_id    = w;
          m_sum   = add_ref(int'((op_a >> (w * W)) & 8'hF), int'((op_b >> (w * W)) & 8'hF));
          m_left  = 2;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          e_valid = 1;
          e_data  = m_sum;
          e_id    = m_id;
          m_ptr   = (m_id + 1) % N;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    tick_no++;
    chk("grant", 32'(grant), 32'(e_grant));
    chk("busy", 32'(busy), 32'(m_left != 0));
    chk("res_valid", 32'(res_valid), 32'(e_valid));
    chk("res_data", 32'(res_data), 32'(e_data));
    chk("res_id", 32'(res_id), 32'(e_id));
  endtask

  int g_tick[$];
  int g_val[$];
  logic [W:0] exp_ff;

  initial begin
    rst = 1'b1; req = 2'b11; op_a = '0; op_b = '0;
    // 1: reset held with requests pending
    tick(); tick();
    chk("t1_grant", 32'(grant), 0);
    chk("t1_busy", 32'(busy), 0);
    rst = 1'b0; req = 2'b01; op_a = 8'h03; op_b = 8'h05;
    // 2: single op on requester 0
    tick();
    chk("t2_grant", 32'(grant), 32'h1);
    req = 2'b00;
    tick();
    chk("t2_novalid", 32'(res_valid), 0);
    tick();
    chk("t2_valid", 32'(res_valid), 1);
    chk("t2_data", 32'(res_data), 32'h08);
    chk("t2_id", 32'(res_id), 0);
    // 3: carry / saturation on requester 1, then a non-overflowing 4'hF sum
    req = 2'b10; op_a = 8'hF0; op_b = 8'hF0;
    tick(); req = 2'b00; tick(); tick();
`ifdef ADDER_SCHED_SAT_EN
    exp_ff = 5'h0F;
`else
    exp_ff = 5'h1E;
`endif
    chk("t3_carry_data", 32'(res_data), 32'(exp_ff));
    chk("t3_carry_id", 32'(res_id), 1);
    req = 2'b01; op_a = 8'h09; op_b = 8'h06;
    tick(); req = 2'b00; tick(); tick();
    chk("t3_96_data", 32'(res_data), 32'h0F);
    // 4: round-robin with both requests held, starting from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    req = 2'b11; op_a = 8'h72; op_b = 8'h41;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (grant != 0) begin
        g_tick.push_back(tick_no);
        g_val.push_back(int'(grant));
      end
    end
    chk("t4_ngrants", 32'(g_val.size()), 4);
    if (g_val.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t4_grant_seq", 32'(g_val[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
        if (i > 0) chk("t4_spacing", 32'(g_tick[i] - g_tick[i-1]), 3);
      end
    end
    req = 2'b00; tick(); tick(); tick();
    // 5: reset during EXEC discards the op and rewinds the pointer
    req = 2'b11; op_a = 8'h5A; op_b = 8'h33;
    tick(); req = 2'b10;
    chk("t5_grant0", 32'(grant), 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    req = 2'b11;
    tick();
    chk("t5_no_valid", 32'(res_valid), 0);
    chk("t5_regrant", 32'(grant), 32'h1);
    req = 2'b00; tick(); tick();
    // 6: req[1] pulsed only while busy is ignored; req[0] then wins with ptr=1
    req = 2'b01; op_a = 8'h21; op_b = 8'h12;
    tick(); req = 2'b10;
    tick(); req = 2'b00;
    chk("t6_no_grant1", 32'(grant[1]), 0);
    tick();
    chk("t6_valid", 32'(res_valid), 1);
    req = 2'b01;
    tick();
    chk("t6_grant0", 32'(grant), 32'h1);
    req = 2'b00; tick(); tick(); tick();
    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 39) == 0);
      req  = N'($urandom_range(0, 3));
      op_a = (N*W)'($urandom);
      op_b = (N*W)'($urandom);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
